// File: rtl/bin_fc_layer_engine.sv
// Binary-input fully-connected layer engine: kernel -> BRAM, stream samples, sign-activate, pack, write back.
// Define BIN_FC_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module bin_fc_layer_engine #(
  parameter int          N_IN        = 200,
  parameter int          N_OUT       = 200,
  parameter int          N_SAMPLES   = 100,
  parameter int          ACC_W       = 16,
  parameter logic [31:0] KERNEL_ADDR = 32'h10000,
  parameter logic [31:0] SAMPLE_ADDR = 32'hE000,
  parameter logic [31:0] RESULT_ADDR = 32'hF000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] av_address,
  output logic        av_read_n,
  output logic        av_write_n,
  output logic [1:0]  av_byteenable,
  output logic [15:0] av_writedata,
  input  logic        av_waitrequest,
  input  logic        av_readdatavalid,
  input  logic [15:0] av_readdata,
  output logic [15:0] bram_addr,
  output logic [15:0] bram_wdata,
  output logic        bram_we,
  input  logic [15:0] bram_rdata,
  input  logic [7:0]  samples_ready,
  output logic [7:0]  samples_done,
  output logic        busy
);
  localparam int          XB        = ((N_IN + 15) / 16) * 16;
  localparam logic [31:0] KW        = 32'((N_OUT * (N_IN + 1) + 1) / 2);
  localparam logic [31:0] IW        = 32'((N_IN + 15) / 16);
  localparam logic [31:0] OW        = 32'((N_OUT + 15) / 16);
  localparam logic [16:0] NODE_B    = 17'(N_IN + 1);
  localparam logic [10:0] STEP_LAST = 11'(N_IN + 1);
  localparam logic [10:0] NODE_LAST = 11'(N_OUT - 1);
  localparam logic [10:0] NODE_END  = 11'(N_OUT);
  localparam logic [7:0]  NSAMP     = 8'(N_SAMPLES);

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD_K = 3'd1, S_LOAD_X = 3'd2, S_CALC = 3'd3,
                         S_ACT  = 3'd4, S_WRITE  = 3'd5, S_SDONE  = 3'd6, S_DONE = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [31:0]      iss_q, iss_d, rcv_q, rcv_d;
  logic [XB-1:0]    x_q, x_d;
  logic [16:0]      base_q, base_d;
  logic [10:0]      step_q, step_d, node_q, node_d;
  logic [15:0]      owrd_q, owrd_d, pack_q, pack_d, wdata_q, wdata_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       sdone_q, sdone_d;
  logic [15:0]      bwaddr_q, bwaddr_d, bwdata_q, bwdata_d;
  logic             bwe_q, bwe_d, lane_q;

  logic             rd_en, rd_acc, x_bit;
  logic [16:0]      rbyte;
  logic [7:0]       bsel;
  logic [ACC_W-1:0] wext;
  logic [XB-1:0]    xs;
  logic [15:0]      pk;
  logic [4:0]       cnt;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = a + b;
`ifdef BIN_FC_ACC_SAT_EN
    if (a[ACC_W-1] == b[ACC_W-1] && s[ACC_W-1] != a[ACC_W-1])
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s;
  endfunction

  assign rd_en  = (state_q == S_LOAD_K && iss_q < KW) ||
                  (state_q == S_LOAD_X && sdone_q < samples_ready && iss_q < IW);
  assign rd_acc = rd_en && !av_waitrequest;

  // Byte pointer for CALC: lane is registered so it lines up with the 1-cycle BRAM read.
  assign rbyte = base_q + 17'(step_q);
  assign bsel  = lane_q ? bram_rdata[15:8] : bram_rdata[7:0];
  assign wext  = {{(ACC_W-8){bsel[7]}}, bsel};
  assign xs    = x_q >> (step_q - 11'd2);
  assign x_bit = xs[0];
  assign pk    = {~acc_q[ACC_W-1], pack_q[15:1]};
  assign cnt   = {1'b0, node_q[3:0]} + 5'd1;

  assign av_read_n     = ~rd_en;
  assign av_write_n    = (state_q != S_WRITE);
  assign av_byteenable = 2'b11;
  assign av_writedata  = wdata_q;
  assign bram_addr     = (state_q == S_CALC) ? rbyte[16:1] : bwaddr_q;
  assign bram_wdata    = bwdata_q;
  assign bram_we       = bwe_q;
  assign samples_done  = sdone_q;
  assign busy          = (state_q != S_IDLE);

  always_comb begin
    case (state_q)
      S_LOAD_K: av_address = KERNEL_ADDR + iss_q;
      S_LOAD_X: av_address = SAMPLE_ADDR + 32'(sdone_q) * IW + iss_q;
      S_WRITE:  av_address = RESULT_ADDR + 32'(sdone_q) * OW + 32'(owrd_q);
      default:  av_address = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;  iss_d = iss_q;    rcv_d = rcv_q;     x_d = x_q;
    base_d = base_q;    step_d = step_q;  node_d = node_q;   owrd_d = owrd_q;
    acc_d = acc_q;      pack_d = pack_q;  wdata_d = wdata_q; sdone_d = sdone_q;
    bwe_d = 1'b0;       bwaddr_d = bwaddr_q; bwdata_d = bwdata_q;
    if (rd_acc) iss_d = iss_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        iss_d = '0; rcv_d = '0; sdone_d = '0; node_d = '0; base_d = '0;
        owrd_d = '0; step_d = '0; pack_d = '0;
        if (samples_ready != 8'd0) state_d = S_LOAD_K;
      end
      S_LOAD_K: if (av_readdatavalid) begin
        bwe_d = 1'b1; bwaddr_d = rcv_q[15:0]; bwdata_d = av_readdata;
        rcv_d = rcv_q + 32'd1;
        if (rcv_q == KW - 32'd1) begin
          state_d = S_LOAD_X; iss_d = '0; rcv_d = '0;
        end
      end
      S_LOAD_X: if (av_readdatavalid) begin
        x_d   = XB'({av_readdata, x_q} >> 16);
        rcv_d = rcv_q + 32'd1;
        if (rcv_q == IW - 32'd1) begin
          state_d = S_CALC; step_d = '0; node_d = '0; base_d = '0; owrd_d = '0; pack_d = '0;
        end
      end
      S_CALC: begin
        if (step_q == 11'd1)                 acc_d = wext;
        else if (step_q != 11'd0 && x_bit)   acc_d = acc_add(acc_q, wext);
        if (step_q == STEP_LAST) begin
          step_d = '0; state_d = S_ACT;
        end else begin
          step_d = step_q + 11'd1;
        end
      end
      S_ACT: begin
        node_d = node_q + 11'd1;
        base_d = base_q + NODE_B;
        if (node_q[3:0] == 4'hF || node_q == NODE_LAST) begin
          wdata_d = pk >> (5'd16 - cnt);  // right-align a partial final word
          pack_d  = '0;
          state_d = S_WRITE;
        end else begin
          pack_d  = pk;
          state_d = S_CALC;
        end
      end
      S_WRITE: if (!av_waitrequest) begin
        owrd_d  = owrd_q + 16'd1;
        state_d = (node_q == NODE_END) ? S_SDONE : S_CALC;
      end
      S_SDONE: begin
        sdone_d = sdone_q + 8'd1;
        iss_d = '0; rcv_d = '0;
        state_d = (sdone_q + 8'd1 == NSAMP) ? S_DONE : S_LOAD_X;
      end
      default: if (samples_ready == 8'd0) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE; iss_q <= '0; rcv_q <= '0; x_q <= '0; base_q <= '0;
      step_q <= '0; node_q <= '0; owrd_q <= '0; acc_q <= '0; pack_q <= '0;
      wdata_q <= '0; sdone_q <= '0; bwe_q <= 1'b0; bwaddr_q <= '0; bwdata_q <= '0;
      lane_q <= 1'b0;
    end else begin
      state_q <= state_d; iss_q <= iss_d; rcv_q <= rcv_d; x_q <= x_d; base_q <= base_d;
      step_q <= step_d; node_q <= node_d; owrd_q <= owrd_d; acc_q <= acc_d; pack_q <= pack_d;
      wdata_q <= wdata_d; sdone_q <= sdone_d; bwe_q <= bwe_d; bwaddr_q <= bwaddr_d;
      bwdata_q <= bwdata_d; lane_q <= rbyte[0];
    end
  end
endmodule

// File: tb/tb_bin_fc_layer_engine.sv
// Directed bench: engine A (16 in, 20 out, 3 samples, random stalls) and engine B (7 in, ACC_W=10 overflow case).
module tb_bin_fc_layer_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;

  typedef struct { logic [31:0] addr; logic [15:0] data; } wr_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- engine A ----------------
  logic [31:0] addr_a; logic rdn_a, wrn_a, bwe_a, busy_a; logic [1:0] be_a;
  logic [15:0] wd_a, baddr_a, bwd_a, brd_a;
  logic wait_a = 1'b0, rdv_a = 1'b0; logic [15:0] rd_a = '0;
  logic [7:0] sr_a = '0, sd_a;
  logic [15:0] ka [170]; logic [15:0] xa [3]; logic [15:0] bmem_a [65536];
  logic [7:0]  kbytes [340];
  logic [31:0] pend_a [$]; wr_t exp_a [$]; wr_t e_a; int nrd_a = 0, ndl_a = 0;

  bin_fc_layer_engine #(.N_IN(16), .N_OUT(20), .N_SAMPLES(3), .ACC_W(16)) u_a (
    .clk(clk), .reset_n(rst_n), .av_address(addr_a), .av_read_n(rdn_a), .av_write_n(wrn_a),
    .av_byteenable(be_a), .av_writedata(wd_a), .av_waitrequest(wait_a),
    .av_readdatavalid(rdv_a), .av_readdata(rd_a), .bram_addr(baddr_a), .bram_wdata(bwd_a),
    .bram_we(bwe_a), .bram_rdata(brd_a), .samples_ready(sr_a), .samples_done(sd_a), .busy(busy_a));

  always @(posedge clk) begin
    if (bwe_a) bmem_a[baddr_a] <= bwd_a;
    brd_a <= bmem_a[baddr_a];
  end

  function automatic logic [15:0] mem_a(input logic [31:0] a);
    if (a >= 32'h10000 && a < 32'h10000 + 170) return ka[int'(a - 32'h10000)];
    if (a >= 32'hE000 && a < 32'hE003) return xa[int'(a - 32'hE000)];
    return 16'hDEAD;
  endfunction

  function automatic int kbyte_a(input int b);
    logic [15:0] w;
    w = ka[b / 2];
    return (b % 2 == 1) ? int'($signed(w[15:8])) : int'($signed(w[7:0]));
  endfunction

  function automatic logic [15:0] exp_word_a(input logic [15:0] x, input int w);
    logic [15:0] r; int acc;
    r = '0;
    for (int j = w * 16; j < 20 && j < w * 16 + 16; j++) begin
      acc = kbyte_a(j * 17);
      for (int i = 0; i < 16; i++) if (x[i]) acc += kbyte_a(j * 17 + 1 + i);
      r[j - w * 16] = (acc >= 0);
    end
    return r;
  endfunction

  // Slave model: decisions made on the falling edge, seen by the DUT on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_a.delete(); rdv_a = 1'b0; wait_a = 1'b0;
    end else begin
      rdv_a = 1'b0;
      if (pend_a.size() > 0 && $urandom_range(0, 2) != 0) begin
        rdv_a = 1'b1; rd_a = mem_a(pend_a.pop_front()); ndl_a++;
      end
      wait_a = ($urandom_range(0, 1) == 1);
      if (!rdn_a && !wait_a) begin pend_a.push_back(addr_a); nrd_a++; end
      if (!wrn_a && !wait_a) begin
        if (exp_a.size() == 0) chk("a_wr_unexpected", addr_a, 32'hFFFF_FFFF);
        else begin
          e_a = exp_a.pop_front();
          chk("a_wr_addr", addr_a, e_a.addr);
          chk("a_wr_data", 32'(wd_a), 32'(e_a.data));
        end
      end
    end
  end

  // ---------------- engine B ----------------
  logic [31:0] addr_b; logic rdn_b, wrn_b, bwe_b, busy_b; logic [1:0] be_b;
  logic [15:0] wd_b, baddr_b, bwd_b, brd_b;
  logic wait_b = 1'b0, rdv_b = 1'b0; logic [15:0] rd_b = '0;
  logic [7:0] sr_b = '0, sd_b;
  logic [15:0] kb [4]; logic [15:0] xb; logic [15:0] bmem_b [65536];
  logic [31:0] pend_b [$]; wr_t exp_b [$]; wr_t e_b; int nrd_b = 0;

  bin_fc_layer_engine #(.N_IN(7), .N_OUT(1), .N_SAMPLES(1), .ACC_W(10)) u_b (
    .clk(clk), .reset_n(rst_n), .av_address(addr_b), .av_read_n(rdn_b), .av_write_n(wrn_b),
    .av_byteenable(be_b), .av_writedata(wd_b), .av_waitrequest(wait_b),
    .av_readdatavalid(rdv_b), .av_readdata(rd_b), .bram_addr(baddr_b), .bram_wdata(bwd_b),
    .bram_we(bwe_b), .bram_rdata(brd_b), .samples_ready(sr_b), .samples_done(sd_b), .busy(busy_b));

  always @(posedge clk) begin
    if (bwe_b) bmem_b[baddr_b] <= bwd_b;
    brd_b <= bmem_b[baddr_b];
  end

  function automatic logic [15:0] mem_b(input logic [31:0] a);
    if (a >= 32'h10000 && a < 32'h10004) return kb[int'(a - 32'h10000)];
    if (a == 32'hE000) return xb;
    return 16'hDEAD;
  endfunction

  function automatic int kbyte_b(input int b);
    logic [15:0] w;
    w = kb[b / 2];
    return (b % 2 == 1) ? int'($signed(w[15:8])) : int'($signed(w[7:0]));
  endfunction

  function automatic logic [15:0] exp_word_b(input logic [15:0] x);
    int acc;
    acc = kbyte_b(0);
    for (int i = 0; i < 7; i++) if (x[i]) begin
      acc += kbyte_b(1 + i);
`ifdef BIN_FC_ACC_SAT_EN
      if (acc > 511) acc = 511;
      if (acc < -512) acc = -512;
`else
      acc = ((acc + 512) & 1023) - 512;
`endif
    end
    return {15'd0, acc >= 0};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_b.delete(); rdv_b = 1'b0; wait_b = 1'b0;
    end else begin
      rdv_b = 1'b0;
      if (pend_b.size() > 0 && $urandom_range(0, 1) != 0) begin
        rdv_b = 1'b1; rd_b = mem_b(pend_b.pop_front());
      end
      wait_b = ($urandom_range(0, 1) == 1);
      if (!rdn_b && !wait_b) begin pend_b.push_back(addr_b); nrd_b++; end
      if (!wrn_b && !wait_b) begin
        if (exp_b.size() == 0) chk("b_wr_unexpected", addr_b, 32'hFFFF_FFFF);
        else begin
          e_b = exp_b.pop_front();
          chk("b_wr_addr", addr_b, e_b.addr);
          chk("b_wr_data", 32'(wd_b), 32'(e_b.data));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic push_exp_a(input int s);
    wr_t e;
    for (int w = 0; w < 2; w++) begin
      e.addr = 32'hF000 + 32'(s * 2 + w);
      e.data = exp_word_a(xa[s], w);
      exp_a.push_back(e);
    end
  endtask

  task automatic set_sr_a(input logic [7:0] v);
    @(posedge clk); #1 sr_a = v;
  endtask

  task automatic wait_sd_a(input logic [7:0] tgt);
    int n;
    n = 0;
    while (sd_a !== tgt && n < 20000) begin @(negedge clk); n++; end
    chk("a_samples_done", 32'(sd_a), 32'(tgt));
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_read_n"},  32'(rdn_a),   32'd1);
    chk({tag, "_write_n"}, 32'(wrn_a),   32'd1);
    chk({tag, "_addr"},    addr_a,       32'd0);
    chk({tag, "_bram_we"}, 32'(bwe_a),   32'd0);
    chk({tag, "_bram_ad"}, 32'(baddr_a), 32'd0);
    chk({tag, "_sdone"},   32'(sd_a),    32'd0);
    chk({tag, "_busy"},    32'(busy_a),  32'd0);
    chk({tag, "_wdata"},   32'(wd_a),    32'd0);
  endtask

  initial begin
    int bad, n, base;
    wr_t eb;
    for (int j = 0; j < 20; j++)
      for (int i = 0; i < 17; i++)
        kbytes[j * 17 + i] = (j < 16) ? ((i == 0) ? 8'hF8 : 8'h01) : 8'($urandom_range(0, 255));
    for (int k = 0; k < 170; k++) ka[k] = {kbytes[2 * k + 1], kbytes[2 * k]};
    xa[0] = 16'h00FF; xa[1] = 16'h007F; xa[2] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < 4; k++) kb[k] = 16'h7F7F;
    xb = 16'hFFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a("a_rst");
    chk("a_rst_byteen", 32'(be_a), 32'd3);
    chk("b_rst_busy", 32'(busy_b), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    push_exp_a(0);
    eb.addr = 32'hF000; eb.data = exp_word_b(xb); exp_b.push_back(eb);
    set_sr_a(8'd1);
    sr_b = 8'd1;
    wait_sd_a(8'd1);

    bad = 0;
    for (int k = 0; k < 170; k++) if (bmem_a[k] !== ka[k]) bad++;
    chk("a_bram_kernel", 32'(bad), 32'd0);

    // Only one sample available: engine must park in LOAD_X without reading.
    bad = 0;
    repeat (30) begin @(negedge clk); if (!rdn_a) bad++; end
    chk("a_stall_read_n", 32'(bad), 32'd0);
    chk("a_stall_busy", 32'(busy_a), 32'd1);
    chk("a_stall_sdone", 32'(sd_a), 32'd1);

    push_exp_a(1); set_sr_a(8'd2); wait_sd_a(8'd2);
    push_exp_a(2); set_sr_a(8'd3); wait_sd_a(8'd3);
    repeat (5) @(negedge clk);
    chk("a_done_busy", 32'(busy_a), 32'd1);
    chk("a_done_sdone", 32'(sd_a), 32'd3);
    chk("a_read_count", 32'(nrd_a), 32'd173);
    chk("a_wr_pending", 32'(exp_a.size()), 32'd0);
    set_sr_a(8'd0);
    repeat (3) @(negedge clk);
    chk("a_idle_busy", 32'(busy_a), 32'd0);
    chk("a_idle_sdone", 32'(sd_a), 32'd0);

    n = 0;
    while (sd_b !== 8'd1 && n < 20000) begin @(negedge clk); n++; end
    chk("b_samples_done", 32'(sd_b), 32'd1);
    chk("b_wr_pending", 32'(exp_b.size()), 32'd0);
    chk("b_read_count", 32'(nrd_b), 32'd5);

    // Restart A and pull reset while it is computing the first sample.
    base = ndl_a;
    set_sr_a(8'd1);
    n = 0;
    while (ndl_a < base + 171 && n < 20000) begin @(negedge clk); n++; end
    chk("a_reload_words", 32'(ndl_a), 32'(base + 171));
    repeat (4) @(negedge clk);
    chk("a_calc_busy", 32'(busy_a), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset_a("a_midrst");
    @(posedge clk); #1 rst_n = 1'b1; sr_a = 8'd0;
    repeat (3) @(negedge clk);
    chk("a_post_rst_busy", 32'(busy_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
